// File: rtl/ap_line_sequencer_pkg.sv
// Shared op codes, status codes and the one-hot state encoding for ap_line_sequencer.
package ap_line_sequencer_pkg;

   localparam logic [1:0] OP_AP_INC   = 2'b00;
   localparam logic [1:0] OP_AP_DEC   = 2'b01;
   localparam logic [1:0] OP_DATA_INC = 2'b10;
   localparam logic [1:0] OP_DATA_DEC = 2'b11;

   localparam logic [1:0] ST_OK        = 2'b00;
   localparam logic [1:0] ST_UNDERFLOW = 2'b01;
   localparam logic [1:0] ST_TIMEOUT   = 2'b10;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_ISSUE = 5'b00010,
      S_GUARD = 5'b00100,
      S_WAIT  = 5'b01000,
      S_DONE  = 5'b10000
   } state_t;

   function automatic logic isDataOp(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/ap_line_sequencer_if.sv
// Command and AP/Data line signals of the sequencer; master is the sequencer side,
// slave is the command issuer plus the line.
interface ap_line_sequencer_if #(parameter int COUNT_WIDTH = 8);

   logic                   CmdValid;
   logic                   CmdReady;
   logic [1:0]             CmdOp;
   logic [COUNT_WIDTH-1:0] CmdCount;
   logic                   Done;
   logic [1:0]             Status;
   logic                   ApRequest;
   logic                   DataRequest;
   logic                   Dec;
   logic                   LineReady;
   logic                   ApZero;
   logic                   DataZero;

   modport master (
      input  CmdValid, CmdOp, CmdCount, LineReady, ApZero, DataZero,
      output CmdReady, Done, Status, ApRequest, DataRequest, Dec
   );

   modport slave (
      output CmdValid, CmdOp, CmdCount, LineReady, ApZero, DataZero,
      input  CmdReady, Done, Status, ApRequest, DataRequest, Dec
   );

endinterface

// File: rtl/ap_line_sequencer_seq_watchdog.sv
// Loadable cycle counter; o_terminal flags the last cycle the line may stay not-ready.
module ap_line_sequencer_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TIMEOUT_WIDTH  = 16
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic i_load,
   input  logic i_inc,
   output logic o_terminal
);

   localparam logic [TIMEOUT_WIDTH-1:0] LP_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_WIDTH-1:0] r_count;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= '0;
      end else if (i_inc && !o_terminal) begin
         r_count <= r_count + TIMEOUT_WIDTH'(1);
      end
   end

   assign o_terminal = (r_count == LP_LAST);

endmodule

// File: rtl/ap_line_sequencer.sv
// Replays one folded tape command as single-step AP/Data requests handshaked on LineReady.
// Optional feature macro: APLINE_UNDERFLOW_GUARD_EN (refuse AP- while ApZero is high).
module ap_line_sequencer
   import ap_line_sequencer_pkg::*;
#(
   parameter int COUNT_WIDTH    = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TIMEOUT_WIDTH  = 16
) (
   input logic                 Clk,
   input logic                 Rst_n,
   ap_line_sequencer_if.master bus
);

   state_t                 r_state;
   state_t                 w_nextState;
   logic                   r_dataOp;
   logic                   r_dec;
   logic [COUNT_WIDTH-1:0] r_remaining;
   logic [1:0]             r_status;
   logic                   r_apRequest;
   logic                   r_dataRequest;

   logic w_accept;
   logic w_active;
   logic w_timeout;
   logic w_underflow;
   logic w_lastStep;
   logic w_issueReq;
   logic w_wdLoad;
   logic w_wdInc;
   logic w_wdTerminal;
   logic w_unused;

   assign w_accept   = (r_state == S_IDLE) && bus.CmdValid;
   assign w_active   = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign w_timeout  = w_active && !bus.LineReady && w_wdTerminal;
   assign w_lastStep = (r_remaining == COUNT_WIDTH'(1));

`ifdef APLINE_UNDERFLOW_GUARD_EN
   assign w_underflow = (r_state == S_ISSUE) && !r_dataOp && r_dec && bus.ApZero;
   assign w_unused    = bus.DataZero;
`else
   assign w_underflow = 1'b0;
   assign w_unused    = bus.DataZero ^ bus.ApZero;
`endif

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (bus.CmdValid) w_nextState = (bus.CmdCount == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (w_underflow || w_timeout) w_nextState = S_DONE;
                  else if (bus.LineReady)       w_nextState = S_GUARD;
         S_GUARD: w_nextState = S_WAIT;
         S_WAIT:  if (w_timeout)                w_nextState = S_DONE;
                  else if (bus.LineReady)       w_nextState = w_lastStep ? S_DONE : S_ISSUE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // The watchdog restarts on every entry into a state that waits on the line.
   always_comb begin
      w_issueReq = (r_state == S_ISSUE) && (w_nextState == S_GUARD);
      w_wdLoad   = (w_nextState != r_state) &&
                   ((w_nextState == S_ISSUE) || (w_nextState == S_WAIT));
      w_wdInc    = w_active && !bus.LineReady;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state       <= S_IDLE;
         r_dataOp      <= 1'b0;
         r_dec         <= 1'b0;
         r_remaining   <= '0;
         r_status      <= ST_OK;
         r_apRequest   <= 1'b0;
         r_dataRequest <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_apRequest   <= w_issueReq && !r_dataOp;
         r_dataRequest <= w_issueReq && r_dataOp;
         if (w_accept) begin
            r_dataOp    <= isDataOp(bus.CmdOp);
            r_dec       <= bus.CmdOp[0];
            r_remaining <= bus.CmdCount;
            r_status    <= ST_OK;
         end else if (w_underflow) begin
            r_status    <= ST_UNDERFLOW;
            r_remaining <= '0;
         end else if (w_timeout) begin
            r_status    <= ST_TIMEOUT;
            r_remaining <= '0;
         end else if ((r_state == S_WAIT) && bus.LineReady) begin
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
         end
      end
   end

   ap_line_sequencer_seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
   ) u_seqWatchdog (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .i_load    (w_wdLoad),
      .i_inc     (w_wdInc),
      .o_terminal(w_wdTerminal)
   );

   assign bus.CmdReady    = (r_state == S_IDLE);
   assign bus.Done        = (r_state == S_DONE);
   assign bus.Status      = r_status;
   assign bus.ApRequest   = r_apRequest;
   assign bus.DataRequest = r_dataRequest;
   assign bus.Dec         = r_dec;

endmodule

// File: tb/tb_ap_line_sequencer.sv
// Randomized bench for ap_line_sequencer: a reactive line model plus a per-command
// timing/result model derived from the step and stall counts.
module tb_ap_line_sequencer;
   import ap_line_sequencer_pkg::*;

   localparam int TC     = 8;
   localparam int CW     = 8;
   localparam int BUDGET = 4000;
`ifdef APLINE_UNDERFLOW_GUARD_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Rst_n;
   int   total = 0;
   int   bad = 0;
   int   wStall [256];

   ap_line_sequencer_if #(.COUNT_WIDTH(CW)) bus ();

   ap_line_sequencer #(
      .COUNT_WIDTH   (CW),
      .TIMEOUT_CYCLES(TC),
      .TIMEOUT_WIDTH (4)
   ) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
      end
   endtask

   task automatic setStalls(input int value);
      for (int i = 0; i < 256; i++) wStall[i] = value;
   endtask

   // Issues one command at a negedge in IDLE and returns at the negedge after Done.
   // s = not-ready cycles before the first step; wStall[i] = busy cycles after step i.
   task automatic applyStimulus(input logic [1:0] op, input int count, input int s, input logic apZero);
      int expCycles, expStatus, expPulses, stall;
      int cyc, busy, pulses, apHigh, dataHigh, bothHigh, decBad, readyBad, doneCycle;
      expStatus = int'(ST_OK);
      expPulses = 0;
      expCycles = 1;
      if (count == 0) begin
         expCycles = 2;
      end else if (GUARD_EN && (op == OP_AP_DEC) && apZero) begin
         expCycles = 3;
         expStatus = int'(ST_UNDERFLOW);
      end else begin
         stall = s;
         for (int i = 0; i < count; i++) begin
            if (stall >= TC) begin
               expCycles += TC;
               expStatus = int'(ST_TIMEOUT);
               break;
            end
            expCycles += stall + 2;
            expPulses++;
            if (wStall[i] >= TC) begin
               expCycles += TC;
               expStatus = int'(ST_TIMEOUT);
               break;
            end
            expCycles += wStall[i] + 1;
            stall = 0;
         end
         expCycles += 1;
      end

      checkOutput("readyBeforeAccept", int'(bus.CmdReady), 1);
      bus.CmdValid  = 1'b1;
      bus.CmdOp     = op;
      bus.CmdCount  = CW'(count);
      bus.ApZero    = apZero;
      bus.DataZero  = 1'($urandom);
      bus.LineReady = 1'($urandom);
      busy = s;
      cyc = 1;
      pulses = 0; apHigh = 0; dataHigh = 0; bothHigh = 0; decBad = 0; readyBad = 0; doneCycle = 0;
      while ((doneCycle == 0) && (cyc < BUDGET)) begin
         @(negedge Clk);
         cyc++;
         bus.CmdValid = 1'b0;
         bus.CmdOp    = 2'($urandom);
         bus.CmdCount = CW'($urandom);
         if (cyc == 2) checkOutput("statusCleared", int'(bus.Status), int'(ST_OK));
         if (bus.ApRequest) apHigh++;
         if (bus.DataRequest) dataHigh++;
         if (bus.ApRequest && bus.DataRequest) bothHigh++;
         if (bus.Dec !== op[0]) decBad++;
         if (bus.CmdReady !== 1'b0) readyBad++;
         if (bus.Done) doneCycle = cyc;
         if (bus.ApRequest || bus.DataRequest) begin
            pulses++;
            busy = (pulses <= 256) ? wStall[pulses-1] : 0;
            bus.LineReady = 1'($urandom);
         end else if (busy > 0) begin
            busy--;
            bus.LineReady = 1'b0;
         end else begin
            bus.LineReady = 1'b1;
         end
      end
      checkOutput("doneSeen", int'(doneCycle != 0), 1);
      checkOutput("doneCycle", doneCycle, expCycles);
      checkOutput("statusAtDone", int'(bus.Status), expStatus);
      checkOutput("apPulses", apHigh, op[1] ? 0 : expPulses);
      checkOutput("dataPulses", dataHigh, op[1] ? expPulses : 0);
      checkOutput("bothHigh", bothHigh, 0);
      checkOutput("decStable", decBad, 0);
      checkOutput("readyLowBusy", readyBad, 0);
      @(negedge Clk);
      bus.LineReady = 1'($urandom);
      checkOutput("donePulseLen", int'(bus.Done), 0);
      checkOutput("readyAfterDone", int'(bus.CmdReady), 1);
      checkOutput("statusHeld", int'(bus.Status), expStatus);
   endtask

   initial begin
      int doneCnt, count, s, r;
      logic [1:0] op;
      bus.CmdValid = 1'b0; bus.CmdOp = 2'b00; bus.CmdCount = '0;
      bus.LineReady = 1'b0; bus.ApZero = 1'b0; bus.DataZero = 1'b0;
      Rst_n = 1'b0;
      repeat (3) @(negedge Clk);
      checkOutput("rstReady", int'(bus.CmdReady), 1);
      checkOutput("rstDone", int'(bus.Done), 0);
      checkOutput("rstStatus", int'(bus.Status), 0);
      checkOutput("rstApReq", int'(bus.ApRequest), 0);
      checkOutput("rstDataReq", int'(bus.DataRequest), 0);
      checkOutput("rstDec", int'(bus.Dec), 0);
      Rst_n = 1'b1;
      @(negedge Clk);

      setStalls(0);
      applyStimulus(OP_DATA_INC, 5, 0, 1'b0);
      setStalls(4);
      applyStimulus(OP_AP_DEC, 3, 4, 1'b0);
      applyStimulus(OP_AP_INC, 0, 0, 1'b0);
      setStalls(0);
      applyStimulus(OP_AP_DEC, 4, 0, 1'b1);
      wStall[0] = TC + 3;
      applyStimulus(OP_DATA_DEC, 5, 0, 1'b0);
      setStalls(TC - 1);
      applyStimulus(OP_DATA_INC, 2, TC - 1, 1'b0);
      setStalls(0);
      applyStimulus(OP_AP_INC, 3, TC, 1'b0);
      applyStimulus(OP_DATA_DEC, 255, 0, 1'b1);

      for (int n = 0; n < 30; n++) begin
         op = 2'($urandom);
         r = int'($urandom_range(0, 9));
         count = (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(1, 12));
         s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TC, TC + 1)) : int'($urandom_range(0, 4));
         for (int i = 0; i < 256; i++) wStall[i] = int'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) wStall[$urandom_range(0, 11)] = int'($urandom_range(TC - 1, TC + 2));
         applyStimulus(op, count, s, 1'($urandom));
      end

      bus.CmdValid = 1'b1; bus.CmdOp = OP_DATA_DEC; bus.CmdCount = CW'(6); bus.LineReady = 1'b1;
      @(negedge Clk);
      bus.CmdValid = 1'b0;
      @(negedge Clk);
      checkOutput("midRstReqSeen", int'(bus.DataRequest), 1);
      bus.LineReady = 1'b0;
      @(negedge Clk);
      checkOutput("midRstDecSet", int'(bus.Dec), 1);
      Rst_n = 1'b0;
      #1;
      checkOutput("midRstReady", int'(bus.CmdReady), 1);
      checkOutput("midRstDone", int'(bus.Done), 0);
      checkOutput("midRstStatus", int'(bus.Status), 0);
      checkOutput("midRstApReq", int'(bus.ApRequest), 0);
      checkOutput("midRstDataReq", int'(bus.DataRequest), 0);
      checkOutput("midRstDec", int'(bus.Dec), 0);
      @(negedge Clk);
      Rst_n = 1'b1;
      bus.LineReady = 1'b1;
      doneCnt = 0;
      repeat (8) begin
         @(negedge Clk);
         if (bus.Done) doneCnt++;
      end
      checkOutput("midRstNoDone", doneCnt, 0);
      checkOutput("midRstReadyAfter", int'(bus.CmdReady), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL globalTimeout: got running, want finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
